// File: rtl/uart_core_cfg.sv
// Configurable UART core: baud tick generator, oversampling receiver and
// transmitter with runtime-selectable parity / stop bits, an RX FIFO and a
// TX FIFO (first-word fall-through), and sticky error flags.

module uart_fifo #(
    parameter int W   = 8,
    parameter int EXP = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic [EXP:0] count,
    output logic         full,
    output logic         empty
);
    localparam logic [EXP:0] DEPTH = {1'b1, {EXP{1'b0}}};

    logic [W-1:0] mem [2**EXP];
    logic [EXP:0] wptr_reg, rptr_reg;
    logic         do_push, do_pop;

    assign count   = wptr_reg - rptr_reg;
    assign full    = (count == DEPTH);
    assign empty   = (count == '0);
    // Push is dropped when full, pop is dropped when empty; this also gives
    // the push-only / pop-only behaviour on simultaneous requests.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr_reg[EXP-1:0]];

    // Storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_reg[EXP-1:0]] <= wdata;
    end

    // Circular pointers with one extra bit so full and empty are distinguishable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
        end else begin
            if (do_push) wptr_reg <= wptr_reg + (EXP+1)'(1);
            if (do_pop)  rptr_reg <= rptr_reg + (EXP+1)'(1);
        end
    end
endmodule

module uart_core_cfg #(
    parameter int DBITS    = 8,
    parameter int SB_TICK  = 16,
    parameter int FIFO_EXP = 3,
    parameter int DIV_BITS = 11
) (
    input  logic                clk_100MHz,
    input  logic                reset,
    input  logic [DIV_BITS-1:0] baud_div,
    input  logic                parity_en,
    input  logic                parity_odd,
    input  logic                stop2,
    input  logic                rx,
    output logic                tx,
    input  logic                tx_wr,
    input  logic [DBITS-1:0]    tx_data,
    output logic                tx_full,
    output logic                tx_busy,
    output logic [FIFO_EXP:0]   tx_count,
    input  logic                rx_rd,
    output logic [DBITS-1:0]    rx_data,
    output logic                rx_empty,
    output logic                rx_full,
    output logic [FIFO_EXP:0]   rx_count,
    input  logic                err_clr,
    output logic                err_frame,
    output logic                err_parity,
    output logic                err_overrun
);
    localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;
    localparam int SW = $clog2(2*SB_TICK);
    localparam int NW = $clog2(DBITS);
    localparam logic [SW-1:0] S_HALF = SW'(SB_TICK/2 - 1);
    localparam logic [SW-1:0] S_BIT  = SW'(SB_TICK - 1);
    localparam logic [SW-1:0] S_BIT2 = SW'(2*SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBITS - 1);

    // ---------------- tick generator ----------------
    logic [DIV_BITS-1:0] div_cnt_reg, div_lat_reg;
    logic                tick;
    assign tick = (div_cnt_reg == div_lat_reg);

    // Divider reloads its limit only at wrap so a new baud_div never cuts a period short.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            div_cnt_reg <= '0;
            div_lat_reg <= '0;
        end else if (tick) begin
            div_cnt_reg <= '0;
            div_lat_reg <= baud_div;
        end else begin
            div_cnt_reg <= div_cnt_reg + DIV_BITS'(1);
        end
    end

    // ---------------- receiver ----------------
    logic [2:0]       rx_sync_reg;
    logic             rx_s, rx_fall;
    logic [2:0]       rx_state_reg;
    logic [SW-1:0]    rx_s_reg;
    logic [NW-1:0]    rx_n_reg;
    logic [DBITS-1:0] rx_b_reg;
    logic             rx_par_en_reg, rx_odd_reg, rx_stop2_reg;
    logic             rx_pe_reg, rx_fe_reg, rx_done_reg;
    logic             rx_push;
    logic [DBITS-1:0] rx_head;

    assign rx_s    = rx_sync_reg[1];
    assign rx_fall = rx_sync_reg[2] & ~rx_sync_reg[1];

    // Synchronise rx and keep one extra stage for falling-edge detection.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) rx_sync_reg <= 3'b111;
        else        rx_sync_reg <= {rx_sync_reg[1:0], rx};
    end

    // RX frame FSM: mid-bit sampling, per-frame parity/framing error capture.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            rx_state_reg  <= IDLE;
            rx_s_reg      <= '0;
            rx_n_reg      <= '0;
            rx_b_reg      <= '0;
            rx_par_en_reg <= 1'b0;
            rx_odd_reg    <= 1'b0;
            rx_stop2_reg  <= 1'b0;
            rx_pe_reg     <= 1'b0;
            rx_fe_reg     <= 1'b0;
            rx_done_reg   <= 1'b0;
        end else begin
            rx_done_reg <= 1'b0;
            case (rx_state_reg)
                IDLE: if (rx_fall) begin
                    rx_state_reg  <= START;
                    rx_s_reg      <= '0;
                    rx_par_en_reg <= parity_en;
                    rx_odd_reg    <= parity_odd;
                    rx_stop2_reg  <= stop2;
                    rx_pe_reg     <= 1'b0;
                    rx_fe_reg     <= 1'b0;
                end
                START: if (tick) begin
                    if (rx_s_reg == S_HALF) begin
                        rx_s_reg     <= '0;
                        rx_n_reg     <= '0;
                        rx_state_reg <= rx_s ? IDLE : DATA;
                    end else rx_s_reg <= rx_s_reg + SW'(1);
                end
                DATA: if (tick) begin
                    if (rx_s_reg == S_BIT) begin
                        rx_s_reg <= '0;
                        rx_b_reg <= {rx_s, rx_b_reg[DBITS-1:1]};
                        if (rx_n_reg == N_LAST) begin
                            rx_n_reg     <= '0;
                            rx_state_reg <= rx_par_en_reg ? PARITY : STOP;
                        end else rx_n_reg <= rx_n_reg + NW'(1);
                    end else rx_s_reg <= rx_s_reg + SW'(1);
                end
                PARITY: if (tick) begin
                    if (rx_s_reg == S_BIT) begin
                        rx_s_reg     <= '0;
                        rx_pe_reg    <= rx_s ^ (^rx_b_reg) ^ rx_odd_reg;
                        rx_state_reg <= STOP;
                    end else rx_s_reg <= rx_s_reg + SW'(1);
                end
                STOP: if (tick) begin
                    if (rx_s_reg == S_BIT) begin
                        rx_s_reg <= '0;
                        if (!rx_s) rx_fe_reg <= 1'b1;
                        if (rx_n_reg == NW'(rx_stop2_reg)) begin
                            rx_state_reg <= IDLE;
                            rx_done_reg  <= 1'b1;
                        end else rx_n_reg <= rx_n_reg + NW'(1);
                    end else rx_s_reg <= rx_s_reg + SW'(1);
                end
                default: rx_state_reg <= IDLE;
            endcase
        end
    end

    assign rx_push = rx_done_reg && !rx_fe_reg && !rx_pe_reg;

    uart_fifo #(.W(DBITS), .EXP(FIFO_EXP)) u_rx_fifo (
        .clk(clk_100MHz), .rst_n(reset), .push(rx_push), .pop(rx_rd),
        .wdata(rx_b_reg), .rdata(rx_head), .count(rx_count),
        .full(rx_full), .empty(rx_empty)
    );
    assign rx_data = rx_empty ? '0 : rx_head;

    // Sticky error flags; a new error wins over a simultaneous clear.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            err_frame   <= 1'b0;
            err_parity  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            if (rx_done_reg && rx_fe_reg) err_frame <= 1'b1;
            else if (err_clr)             err_frame <= 1'b0;
            if (rx_done_reg && rx_pe_reg) err_parity <= 1'b1;
            else if (err_clr)             err_parity <= 1'b0;
            if (rx_push && rx_full)       err_overrun <= 1'b1;
            else if (err_clr)             err_overrun <= 1'b0;
        end
    end

    // ---------------- transmitter ----------------
    logic [2:0]       tx_state_reg;
    logic [SW-1:0]    tx_s_reg;
    logic [NW-1:0]    tx_n_reg;
    logic [DBITS-1:0] tx_b_reg, tx_head;
    logic             tx_par_reg, tx_par_en_reg, tx_stop2_reg;
    logic             tx_empty, tx_load, tx_stop_end;

    assign tx_stop_end = (tx_state_reg == STOP) && tick &&
                         (tx_s_reg == (tx_stop2_reg ? S_BIT2 : S_BIT));
    // A new frame starts from IDLE or straight out of the last stop tick.
    assign tx_load = !tx_empty && ((tx_state_reg == IDLE) || tx_stop_end);
    assign tx_busy = (tx_state_reg != IDLE);

    uart_fifo #(.W(DBITS), .EXP(FIFO_EXP)) u_tx_fifo (
        .clk(clk_100MHz), .rst_n(reset), .push(tx_wr), .pop(tx_load),
        .wdata(tx_data), .rdata(tx_head), .count(tx_count),
        .full(tx_full), .empty(tx_empty)
    );

    // TX frame FSM: each bit held SB_TICK ticks, frame options latched at load.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            tx_state_reg  <= IDLE;
            tx_s_reg      <= '0;
            tx_n_reg      <= '0;
            tx_b_reg      <= '0;
            tx_par_reg    <= 1'b0;
            tx_par_en_reg <= 1'b0;
            tx_stop2_reg  <= 1'b0;
        end else if (tx_load) begin
            tx_state_reg  <= START;
            tx_s_reg      <= '0;
            tx_n_reg      <= '0;
            tx_b_reg      <= tx_head;
            tx_par_reg    <= (^tx_head) ^ parity_odd;
            tx_par_en_reg <= parity_en;
            tx_stop2_reg  <= stop2;
        end else if (tick) begin
            case (tx_state_reg)
                START: if (tx_s_reg == S_BIT) begin
                    tx_s_reg     <= '0;
                    tx_state_reg <= DATA;
                end else tx_s_reg <= tx_s_reg + SW'(1);
                DATA: if (tx_s_reg == S_BIT) begin
                    tx_s_reg <= '0;
                    tx_b_reg <= tx_b_reg >> 1;
                    if (tx_n_reg == N_LAST) begin
                        tx_n_reg     <= '0;
                        tx_state_reg <= tx_par_en_reg ? PARITY : STOP;
                    end else tx_n_reg <= tx_n_reg + NW'(1);
                end else tx_s_reg <= tx_s_reg + SW'(1);
                PARITY: if (tx_s_reg == S_BIT) begin
                    tx_s_reg     <= '0;
                    tx_state_reg <= STOP;
                end else tx_s_reg <= tx_s_reg + SW'(1);
                STOP: if (tx_stop_end) tx_state_reg <= IDLE;
                      else             tx_s_reg <= tx_s_reg + SW'(1);
                default: tx_state_reg <= IDLE;
            endcase
        end
    end

    // Line level follows the current TX state; idle and stop drive mark (1).
    always_comb begin
        tx = 1'b1;
        case (tx_state_reg)
            START:   tx = 1'b0;
            DATA:    tx = tx_b_reg[0];
            PARITY:  tx = tx_par_reg;
            default: tx = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_uart_core_cfg.sv
// Directed self-checking bench for uart_core_cfg (baud_div=3 -> 4 clocks/tick).
`timescale 1ns/1ps
module tb_uart_core_cfg;
    localparam int CPT = 4;   // clocks per tick at baud_div=3

    logic       clk_100MHz = 1'b0;
    logic       reset = 1'b1;
    logic [10:0] baud_div = 11'd3;
    logic       parity_en = 1'b0, parity_odd = 1'b0, stop2 = 1'b0;
    logic       rx, tx, rx_drv = 1'b1, loop_en = 1'b0;
    logic       tx_wr = 1'b0, tx_full, tx_busy;
    logic [7:0] tx_data = 8'h00;
    logic [3:0] tx_count, rx_count;
    logic       rx_rd = 1'b0, rx_empty, rx_full, err_clr = 1'b0;
    logic [7:0] rx_data;
    logic       err_frame, err_parity, err_overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int busy_clks;
    logic [7:0] exp_v [1:9];
    logic [7:0] b2b_v [4];

    assign rx = loop_en ? tx : rx_drv;
    always #5 clk_100MHz = ~clk_100MHz;

    uart_core_cfg dut (
        .clk_100MHz(clk_100MHz), .reset(reset), .baud_div(baud_div),
        .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
        .rx(rx), .tx(tx), .tx_wr(tx_wr), .tx_data(tx_data),
        .tx_full(tx_full), .tx_busy(tx_busy), .tx_count(tx_count),
        .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty),
        .rx_full(rx_full), .rx_count(rx_count), .err_clr(err_clr),
        .err_frame(err_frame), .err_parity(err_parity), .err_overrun(err_overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        n_checks++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic drive_bit(input logic b, input int ticks);
        rx_drv = b;
        repeat (ticks * CPT) @(negedge clk_100MHz);
    endtask

    // par < 0: no parity bit; stop_ok=0 drives the stop bit low for 3/4 of a bit.
    task automatic send_frame(input logic [7:0] d, input int par, input logic stop_ok);
        $display("rx frame %02h par %0d stop_ok %0b", d, par, stop_ok);
        drive_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) drive_bit(d[i], 16);
        if (par >= 0) drive_bit(par[0], 16);
        if (stop_ok) drive_bit(1'b1, 16);
        else begin
            drive_bit(1'b0, 12);
            drive_bit(1'b1, 4);
        end
        drive_bit(1'b1, 16);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] expd);
        chk(tag, rx_data, expd);
        $display("rx read %02h", rx_data);
        rx_rd = 1'b1;
        @(negedge clk_100MHz);
        rx_rd = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk_100MHz);
        err_clr = 1'b0;
    endtask

    task automatic wait_busy_rise(input string tag);
        int k;
        k = 0;
        while (!tx_busy && k < 10) begin
            @(negedge clk_100MHz);
            k++;
        end
        chk(tag, tx_busy, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset acts without a clock edge.
        #1 reset = 1'b0;
        #1;
        chk("rst_tx", tx, 1'b1);
        chk("rst_tx_busy", tx_busy, 1'b0);
        chk("rst_tx_full", tx_full, 1'b0);
        chk("rst_tx_count", tx_count, 4'd0);
        chk("rst_rx_empty", rx_empty, 1'b1);
        chk("rst_rx_full", rx_full, 1'b0);
        chk("rst_rx_count", rx_count, 4'd0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_errs", {err_frame, err_parity, err_overrun}, 3'b000);
        repeat (3) @(negedge clk_100MHz);
        reset = 1'b1;
        repeat (5) @(negedge clk_100MHz);

        // Pop on empty RX FIFO is ignored.
        rx_rd = 1'b1;
        @(negedge clk_100MHz);
        rx_rd = 1'b0;
        chk("rd_empty_count", rx_count, 4'd0);
        chk("rd_empty_flag", rx_empty, 1'b1);

        // Loopback 0xA5, 8N1: 10 bits * 16 ticks * 4 clocks, first tick phase free.
        loop_en = 1'b1;
        tx_data = 8'hA5;
        tx_wr = 1'b1;
        @(negedge clk_100MHz);
        tx_wr = 1'b0;
        $display("tx write %02h", 8'hA5);
        wait_busy_rise("lb_busy_rise");
        busy_clks = 0;
        while (tx_busy && busy_clks < 5000) begin
            busy_clks++;
            @(negedge clk_100MHz);
        end
        chk_range("lb_busy_len", busy_clks, 637, 640);
        repeat (4) @(negedge clk_100MHz);
        chk("lb_tx_idle", tx, 1'b1);
        chk("lb_rx_count", rx_count, 4'd1);
        pop_check("lb_rx_data", 8'hA5);
        chk("lb_rx_empty", rx_empty, 1'b1);
        chk("lb_rx_data_empty", rx_data, 8'h00);
        loop_en = 1'b0;
        repeat (8) @(negedge clk_100MHz);

        // Even parity: 0x03 has even parity bit 0, send 1.
        parity_en = 1'b1;
        parity_odd = 1'b0;
        send_frame(8'h03, 1, 1'b1);
        chk("par_err_set", err_parity, 1'b1);
        chk("par_rx_empty", rx_empty, 1'b1);
        chk("par_no_frame", err_frame, 1'b0);
        pulse_clr();
        chk("par_err_clr", err_parity, 1'b0);
        send_frame(8'h03, 0, 1'b1);
        chk("par_ok_err", err_parity, 1'b0);
        pop_check("par_ok_data", 8'h03);
        // Odd parity: 0x07 has three ones, odd parity bit 0.
        parity_odd = 1'b1;
        send_frame(8'h07, 0, 1'b1);
        chk("odd_ok_err", err_parity, 1'b0);
        pop_check("odd_ok_data", 8'h07);
        parity_en = 1'b0;
        parity_odd = 1'b0;

        // Stop bit low.
        send_frame(8'h5A, -1, 1'b0);
        chk("fe_set", err_frame, 1'b1);
        chk("fe_rx_empty", rx_empty, 1'b1);
        chk("fe_no_parity", err_parity, 1'b0);
        pulse_clr();
        chk("fe_clr", err_frame, 1'b0);

        // 3-tick glitch on rx.
        drive_bit(1'b0, 3);
        drive_bit(1'b1, 32);
        chk("glitch_empty", rx_empty, 1'b1);
        chk("glitch_errs", {err_frame, err_parity, err_overrun}, 3'b000);

        // Nine frames without reads: ninth overruns.
        for (int k = 1; k <= 9; k++) begin
            exp_v[k] = 8'(k * 37 + 5);
            send_frame(exp_v[k], -1, 1'b1);
        end
        chk("ovr_full", rx_full, 1'b1);
        chk("ovr_count", rx_count, 4'd8);
        chk("ovr_flag", err_overrun, 1'b1);
        for (int k = 1; k <= 8; k++) pop_check($sformatf("ovr_read%0d", k), exp_v[k]);
        chk("ovr_drained", rx_empty, 1'b1);
        pulse_clr();
        chk("ovr_clr", err_overrun, 1'b0);

        // Four writes in consecutive clocks: continuous busy for 4 frames.
        loop_en = 1'b1;
        b2b_v[0] = 8'hC3; b2b_v[1] = 8'h3C; b2b_v[2] = 8'h81; b2b_v[3] = 8'h7E;
        for (int k = 0; k < 4; k++) begin
            tx_data = b2b_v[k];
            tx_wr = 1'b1;
            $display("tx write %02h", b2b_v[k]);
            @(negedge clk_100MHz);
        end
        tx_wr = 1'b0;
        chk("b2b_tx_count", tx_count, 4'd3);
        chk("b2b_busy", tx_busy, 1'b1);
        busy_clks = 2;   // busy already seen at two earlier negedges
        while (tx_busy && busy_clks < 6000) begin
            busy_clks++;
            @(negedge clk_100MHz);
        end
        chk_range("b2b_busy_len", busy_clks, 3*640 + 637, 4*640);
        repeat (6) @(negedge clk_100MHz);
        chk("b2b_rx_count", rx_count, 4'd4);
        for (int k = 0; k < 4; k++) pop_check($sformatf("b2b_read%0d", k), b2b_v[k]);
        loop_en = 1'b0;

        // Ten writes: FIFO fills at 8, tenth ignored; then reset mid-frame.
        for (int k = 0; k < 10; k++) begin
            tx_data = 8'(k * 2);
            tx_wr = 1'b1;
            @(negedge clk_100MHz);
        end
        tx_wr = 1'b0;
        chk("full_flag", tx_full, 1'b1);
        chk("full_count", tx_count, 4'd8);
        repeat (100) @(negedge clk_100MHz);
        chk("mid_busy", tx_busy, 1'b1);
        chk("mid_tx_low", tx, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("mrst_tx", tx, 1'b1);
        chk("mrst_busy", tx_busy, 1'b0);
        chk("mrst_tx_count", tx_count, 4'd0);
        chk("mrst_tx_full", tx_full, 1'b0);
        @(negedge clk_100MHz);
        reset = 1'b1;
        repeat (700) @(negedge clk_100MHz);
        chk("post_rst_busy", tx_busy, 1'b0);
        chk("post_rst_tx", tx, 1'b1);
        chk("post_rst_rx_empty", rx_empty, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_core_cfg.md
UART_CORE_CFG -- requirements
Module: uart_core_cfg

Interface
REQ-001 Parameters SHALL be as follows.
- DBITS, 8: data bits per frame, 5..9.
- SB_TICK, 16: oversampling ticks per bit.
- FIFO_EXP, 3: log2 of the RX and TX FIFO depth.
- DIV_BITS, 11: width of baud_div.
REQ-002 Ports SHALL be as follows.
- clk_100MHz  in  1: the single clock.
- reset  in  1: asynchronous, active-low; asserted at 0.
- baud_div  in  DIV_BITS: sample tick every baud_div+1 clocks.
- parity_en  in  1: parity bit present.
- parity_odd  in  1: 1 = odd parity, 0 = even parity.
- stop2  in  1: 1 = two stop bits.
- rx  in  1: serial data in.
- tx  out  1: serial data out.
- tx_wr  in  1: push tx_data into the TX FIFO.
- tx_data  in  DBITS: word to transmit.
- tx_full  out  1: TX FIFO full.
- tx_busy  out  1: transmitter not idle.
- tx_count  out  FIFO_EXP+1: TX FIFO occupancy.
- rx_rd  in  1: pop the RX FIFO head.
- rx_data  out  DBITS: RX FIFO head (first-word fall-through).
- rx_empty  out  1: RX FIFO empty.
- rx_full  out  1: RX FIFO full.
- rx_count  out  FIFO_EXP+1: RX FIFO occupancy.
- err_clr  in  1: clear all error flags.
- err_frame, err_parity, err_overrun  out  1 each: sticky error flags.

Function
REQ-003 Tick generator SHALL count 0..baud_div, pulse tick for one clock when count==baud_div, then wrap to 0; a new baud_div SHALL take effect at the next wrap; baud_div=0 SHALL give a tick on every clock.
REQ-004 Frame format SHALL be: start bit (0), DBITS data bits LSB first, optional parity bit, then 1 or 2 stop bits (1); one bit lasts SB_TICK ticks.
REQ-005 Parity: the even-parity bit SHALL be the XOR of the data bits; odd parity SHALL be its inverse.
REQ-006 parity_en, parity_odd and stop2 SHALL be latched at each frame start, so changes mid-frame SHALL NOT affect the frame in progress.
REQ-007 RX FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
- IDLE -> START when rx=0.
- START: rx re-sampled after SB_TICK/2 ticks; if 1, return to IDLE (glitch, no flag); else go to DATA.
- DATA and PARITY bits sampled every SB_TICK ticks after that mid-bit point.
REQ-008 RX stop handling: in STOP, rx SHALL be sampled at mid-bit of each stop bit; a 0 on any stop sample SHALL set err_frame.
REQ-009 RX parity mismatch SHALL set err_parity.
REQ-010 RX completion: a word SHALL be pushed to the RX FIFO one clock after the final stop sample only if there is no frame or parity error; an errored word SHALL be discarded.
REQ-011 A valid word arriving while rx_full=1 SHALL be discarded and set err_overrun; FIFO contents SHALL be unchanged.
REQ-012 TX FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
- IDLE -> START when the TX FIFO is non-empty; the head word is popped in that same clock.
- Each bit is held SB_TICK ticks; PARITY is skipped when parity_en=0.
- STOP lasts SB_TICK or 2*SB_TICK ticks.
- After STOP, go to IDLE, or directly to START when the FIFO is non-empty (back-to-back frames, no idle gap).
REQ-013 tx_busy SHALL be 1 in every TX state except IDLE; tx SHALL be 1 in IDLE and STOP.
REQ-014 Both FIFOs SHALL be 2**FIFO_EXP deep.
- Circular read and write pointers wrap at depth.
- count = write pointer minus read pointer, width FIFO_EXP+1.
- full when count==depth; empty when count==0.
REQ-015 FIFO boundary rules:
- tx_wr while tx_full=1 SHALL be ignored.
- rx_rd while rx_empty=1 SHALL be ignored.
- Simultaneous push and pop on a non-empty, non-full FIFO SHALL leave count unchanged.
- Simultaneous push and pop when empty SHALL perform the push only.
- Simultaneous push and pop when full SHALL perform the pop only.
REQ-016 rx_data SHALL show the head word combinationally from the FIFO registers when rx_empty=0, and SHALL be 0 when rx_empty=1.
REQ-017 Error flags SHALL stay set until err_clr=1; if err_clr and a new error occur in the same clock, the flag SHALL be set.

Reset
REQ-018 While reset=0, all of the following SHALL hold immediately, independent of the clock:
- tx=1, tx_busy=0, tx_full=0, tx_count=0.
- rx_empty=1, rx_full=0, rx_count=0, rx_data=0.
- All error flags 0; both FSMs in IDLE; tick counter 0.
REQ-019 Reset asserted mid-frame SHALL abort the frame and discard FIFO contents; after release, RX SHALL wait for a fresh falling edge on rx.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Loopback tx->rx, baud_div=3, 8N1, write 0xA5 -> tx_busy for 640 clocks; rx_data=0xA5, rx_count=1.
- Even parity, 0x03 sent with injected parity bit 1 -> err_parity=1, rx_empty stays 1; err_clr -> err_parity=0.
- Nine valid frames with no reads, depth 8 -> rx_full=1, rx_count=8, err_overrun=1; reads return frames 1..8 in order.
- Stop bit driven 0 -> err_frame=1, nothing pushed.
- rx pulsed low for 3 ticks -> no frame, no flags.
- Four tx_wr in consecutive clocks -> four back-to-back frames with no idle gap between them.
- reset=0 mid-transmit -> tx=1 immediately, tx_count=0.
